// File: rtl/compositor_pkg.sv
// Shared types, default colours and helpers for the layer compositor.
// Game-state encoding as presented alongside the sprite hit flags.
package compositor_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned RGB_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      TITLE     = 3'b000,
      GAME_A    = 3'b001,
      GAME_B    = 3'b010,
      GAME_OVER = 3'b011,
      GAME_C    = 3'b100
   } game_state_e;

   localparam logic [23:0] DEF_TRANSPARENT = 24'hF442EE;
   localparam logic [23:0] DEF_BG_COLOR    = 24'h0000F0;
   localparam logic [23:0] DEF_TITLE_COLOR = 24'h00F0F0;

   // True for the states that draw the playfield (sprites, cursor, sky).
   function automatic logic is_game_state(input logic [STATE_W-1:0] s);
      logic r;
      r = 1'b0;
      case (s)
         GAME_A, GAME_B, GAME_C: r = 1'b1;
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/layer_compositor_pipe_delay.sv
// Fixed-depth register delay line with synchronous clear; DEPTH=0 is a wire.
module pipe_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign q = d;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= d;
               for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/layer_compositor.sv
// Merges N prioritised sprite layers, cursor with shot flash and game-state
// screen modes into registered VGA RGB, hiding palette ROM latency.
module layer_compositor
   import compositor_pkg::*;
#(
   parameter int unsigned         NUM_LAYERS   = 4,
   parameter int unsigned         COLOR_W      = 24,
   parameter int unsigned         ROM_LAT      = 2,
   parameter logic [COLOR_W-1:0]  TRANSPARENT  = COLOR_W'(DEF_TRANSPARENT),
   parameter logic [COLOR_W-1:0]  BG_COLOR     = COLOR_W'(DEF_BG_COLOR),
   parameter logic [COLOR_W-1:0]  TITLE_COLOR  = COLOR_W'(DEF_TITLE_COLOR),
   parameter int unsigned         FLASH_FRAMES = 4
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          frame_start,
   input  logic                          pixel_en,
   input  logic [STATE_W-1:0]            state,
   input  logic [NUM_LAYERS-1:0]         layer_hit,
   input  logic                          is_cursor,
   input  logic                          shot,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
   output logic [RGB_W-1:0]              VGA_R,
   output logic [RGB_W-1:0]              VGA_G,
   output logic [RGB_W-1:0]              VGA_B,
   output logic                          pix_valid
);

   localparam int unsigned FLAG_W  = NUM_LAYERS + 1 + STATE_W + 1;
   localparam int unsigned FLASH_W = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
   localparam int unsigned CH_W    = COLOR_W / 3;

   logic [FLAG_W-1:0]     d_flags;
   logic [NUM_LAYERS-1:0] d_hit;
   logic                  d_cursor;
   logic [STATE_W-1:0]    d_state;
   logic                  d_en;

   logic [FLASH_W-1:0]    flash_cnt;
   logic                  shot_q;

   logic [COLOR_W-1:0]    comp_c;
   logic                  sel_found;

   // Flags wait here until the palette colour for the same pixel arrives.
   pipe_delay #(
      .WIDTH (FLAG_W),
      .DEPTH (ROM_LAT)
   ) u_flag_delay (
      .clk   (Clk),
      .reset (Reset),
      .d     ({layer_hit, is_cursor, state, pixel_en}),
      .q     (d_flags)
   );

   assign {d_hit, d_cursor, d_state, d_en} = d_flags;

   // Shot flash: rising edge reloads, frame_start counts down to zero.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         shot_q    <= 1'b0;
         flash_cnt <= '0;
      end else begin
         shot_q <= shot;
         if (shot && !shot_q) begin
            flash_cnt <= FLASH_W'(FLASH_FRAMES);
         end else if (frame_start && (flash_cnt != '0)) begin
            flash_cnt <= flash_cnt - FLASH_W'(1);
         end
      end
   end

   // Pixel composition on the delayed flags and live palette data.
   always_comb begin
      comp_c    = '0;
      sel_found = 1'b0;
      if (d_en) begin
         if (d_state == TITLE) begin
            comp_c = TITLE_COLOR;
         end else if (is_game_state(d_state)) begin
            if (d_cursor) begin
               comp_c = (flash_cnt != '0) ? '0 : {COLOR_W{1'b1}};
            end else begin
               comp_c = BG_COLOR;
               for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                  if (!sel_found && d_hit[i] &&
                      (layer_color[i*COLOR_W +: COLOR_W] != TRANSPARENT)) begin
                     comp_c    = layer_color[i*COLOR_W +: COLOR_W];
                     sel_found = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         pix_valid <= 1'b0;
      end else begin
         VGA_R     <= comp_c[3*CH_W-1 -: RGB_W];
         VGA_G     <= comp_c[2*CH_W-1 -: RGB_W];
         VGA_B     <= comp_c[CH_W-1 -: RGB_W];
         pix_valid <= d_en;
      end
   end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: per-cycle stimulus, bench-side
// reference model, expected pixels queued at drive time and popped on output.
module tb_layer_compositor;
   import compositor_pkg::*;

   localparam int unsigned NL = 4;
   localparam int unsigned CW = 24;
   localparam int unsigned RL = 2;
   localparam int          FF = 4;

   logic            Clk = 1'b0;
   logic            Reset, frame_start, pixel_en, is_cursor, shot;
   logic [2:0]      state;
   logic [NL-1:0]   layer_hit;
   logic [NL*CW-1:0] layer_color;
   logic [7:0]      VGA_R, VGA_G, VGA_B;
   logic            pix_valid;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic            rst;
      logic            fs;
      logic            sh;
      logic            en;
      logic [2:0]      st;
      logic            cur;
      logic [NL-1:0]   hit;
      logic [NL*CW-1:0] col;
   } stim_t;

   typedef struct packed {
      logic          v;
      logic [CW-1:0] rgb;
   } exp_t;

   stim_t pend[$];
   exp_t  expq[$];
   int    m_cnt = 0;
   logic  m_shq = 1'b0;

   always #5 Clk = ~Clk;

   layer_compositor dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_start (frame_start),
      .pixel_en    (pixel_en),
      .state       (state),
      .layer_hit   (layer_hit),
      .is_cursor   (is_cursor),
      .shot        (shot),
      .layer_color (layer_color),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .pix_valid   (pix_valid)
   );

   function automatic logic [NL*CW-1:0] col4(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                             input logic [CW-1:0] c2, input logic [CW-1:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   function automatic stim_t mk(input logic [2:0] st, input logic [NL-1:0] hit, input logic cur,
                                input logic en, input logic [NL*CW-1:0] col,
                                input logic sh, input logic fs);
      stim_t s;
      s.rst = 1'b0; s.fs = fs; s.sh = sh; s.en = en;
      s.st = st; s.cur = cur; s.hit = hit; s.col = col;
      return s;
   endfunction

   // Reference pixel: highest-index-first scan so the lowest valid index wins last.
   function automatic exp_t model(input stim_t p, input int cnt);
      exp_t e;
      e.v   = p.en;
      e.rgb = 24'h000000;
      if (p.en) begin
         if (p.st == 3'b000) e.rgb = 24'h00F0F0;
         else if (p.st == 3'b001 || p.st == 3'b010 || p.st == 3'b100) begin
            if (p.cur) e.rgb = (cnt != 0) ? 24'h000000 : 24'hFFFFFF;
            else begin
               e.rgb = 24'h0000F0;
               for (int i = NL - 1; i >= 0; i--)
                  if (p.hit[i] && p.col[i*CW +: CW] != 24'hF442EE) e.rgb = p.col[i*CW +: CW];
            end
         end
      end
      return e;
   endfunction

   // One clock: drive flags now, colour of the pixel issued RL cycles ago, queue its result.
   task automatic tick(input stim_t s);
      stim_t p, z;
      exp_t  e;
      Reset = s.rst; frame_start = s.fs; shot = s.sh; pixel_en = s.en;
      state = s.st; is_cursor = s.cur; layer_hit = s.hit;
      if (s.rst) begin
         layer_color = s.col;
         e.v = 1'b0; e.rgb = '0;
         expq.push_back(e);
         pend.delete();
         for (int i = 0; i < RL; i++) begin
            z = '0;
            z.col = {$urandom, $urandom, $urandom};
            pend.push_back(z);
         end
         m_cnt = 0; m_shq = 1'b0;
      end else begin
         pend.push_back(s);
         p = pend.pop_front();
         layer_color = p.col;
         expq.push_back(model(p, m_cnt));
         if (s.sh && !m_shq) m_cnt = FF;
         else if (s.fs && m_cnt != 0) m_cnt--;
         m_shq = s.sh;
      end
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic test_reset();
      stim_t s;
      exp_t  e;
      for (int k = 0; k < 7; k++) begin
         s = mk(3'b001, 4'b0001, 1'b0, 1'b1, col4(24'h112233, 0, 0, 0), 1'b0, 1'b0);
         s.rst = (k < 3);
         tick(s);
         e = expq.pop_front(); checks++;
         if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {e.v, e.rgb}) begin
            failures++;
            $display("FAIL reset[%0d]: got v=%b rgb=%h%h%h expected v=%b rgb=%h",
                     k, pix_valid, VGA_R, VGA_G, VGA_B, e.v, e.rgb);
         end
         if (k >= 3 && k < 3 + RL) begin
            checks++;
            if (pix_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
               failures++;
               $display("FAIL reset_refill[%0d]: got v=%b rgb=%h%h%h expected v=0 rgb=000000",
                        k, pix_valid, VGA_R, VGA_G, VGA_B);
            end
         end
         if (k == 3 + RL) begin
            checks++;
            if (pix_valid !== 1'b1 || {VGA_R, VGA_G, VGA_B} !== 24'h112233) begin
               failures++;
               $display("FAIL reset_first_pixel: got v=%b rgb=%h%h%h expected v=1 rgb=112233",
                        pix_valid, VGA_R, VGA_G, VGA_B);
            end
         end
      end
   endtask

   task automatic test_priority();
      stim_t tbl[9];
      exp_t  e;
      tbl[0] = mk(3'b001, 4'b0011, 0, 1, col4(24'hF442EE, 24'h123456, 24'hAAAAAA, 24'hBBBBBB), 0, 0);
      tbl[1] = mk(3'b001, 4'b0000, 0, 1, col4(24'h111111, 24'h222222, 24'h333333, 24'h444444), 0, 0);
      tbl[2] = mk(3'b000, 4'b1111, 0, 1, col4(24'h111111, 24'h222222, 24'h333333, 24'h444444), 0, 0);
      tbl[3] = mk(3'b011, 4'b0001, 0, 1, col4(24'h111111, 24'h222222, 24'h333333, 24'h444444), 0, 0);
      tbl[4] = mk(3'b001, 4'b0101, 0, 1, col4(24'hF442EE, 24'h777777, 24'hF442EE, 24'h888888), 0, 0);
      tbl[5] = mk(3'b010, 4'b1100, 0, 1, col4(24'h010101, 24'h020202, 24'hF442EE, 24'hABCDEF), 0, 0);
      tbl[6] = mk(3'b100, 4'b0001, 0, 0, col4(24'h123123, 24'h020202, 24'h030303, 24'h040404), 0, 0);
      tbl[7] = mk(3'b111, 4'b0001, 0, 1, col4(24'h123123, 24'h020202, 24'h030303, 24'h040404), 0, 0);
      tbl[8] = mk(3'b100, 4'b1110, 0, 1, col4(24'h999999, 24'h0A0B0C, 24'h0D0E0F, 24'h101010), 0, 0);
      for (int k = 0; k < 9; k++) begin
         tick(tbl[k]);
         e = expq.pop_front(); checks++;
         if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {e.v, e.rgb}) begin
            failures++;
            $display("FAIL priority[%0d]: got v=%b rgb=%h%h%h expected v=%b rgb=%h",
                     k, pix_valid, VGA_R, VGA_G, VGA_B, e.v, e.rgb);
         end
         if (k == RL) begin
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) begin
               failures++;
               $display("FAIL latency: got rgb=%h%h%h expected 123456", VGA_R, VGA_G, VGA_B);
            end
         end
      end
   endtask

   task automatic test_flash();
      stim_t s;
      exp_t  e;
      logic  sh, fs;
      for (int t = 0; t < 45; t++) begin
         sh = (t < 40) || (t >= 42);
         fs = (t > 0) && (t % 3 == 0);
         s = mk(3'b001, 4'b0000, 1'b1, 1'b1, col4(24'h111111, 0, 0, 0), sh, fs);
         tick(s);
         e = expq.pop_front(); checks++;
         if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {e.v, e.rgb}) begin
            failures++;
            $display("FAIL flash[%0d]: got v=%b rgb=%h%h%h expected v=%b rgb=%h",
                     t, pix_valid, VGA_R, VGA_G, VGA_B, e.v, e.rgb);
         end
         if (t == 12 || t == 44) begin
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
               failures++;
               $display("FAIL flash_black[%0d]: got rgb=%h%h%h expected 000000", t, VGA_R, VGA_G, VGA_B);
            end
         end
         if (t == 13 || t == 38) begin
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
               failures++;
               $display("FAIL flash_white[%0d]: got rgb=%h%h%h expected FFFFFF", t, VGA_R, VGA_G, VGA_B);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      exp_t  e;
      for (int k = 0; k < 10; k++) begin
         s = mk(3'b001, (k % 2 == 0) ? 4'b1000 : 4'b0001, 1'b0, 1'b1,
                col4(24'hFF0000, 24'h000000, 24'h000000, 24'h00FF00), 1'b0, 1'b0);
         tick(s);
         e = expq.pop_front(); checks++;
         if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {e.v, e.rgb}) begin
            failures++;
            $display("FAIL b2b[%0d]: got v=%b rgb=%h%h%h expected v=%b rgb=%h",
                     k, pix_valid, VGA_R, VGA_G, VGA_B, e.v, e.rgb);
         end
         if (k >= RL + 1) begin
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== (((k - RL) % 2 == 0) ? 24'h00FF00 : 24'hFF0000)) begin
               failures++;
               $display("FAIL b2b_alternate[%0d]: got rgb=%h%h%h", k, VGA_R, VGA_G, VGA_B);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      stim_t s;
      exp_t  e;
      for (int k = 0; k < 10; k++) begin
         s = mk(3'b001, 4'b0000, 1'b1, 1'b1, col4(24'h111111, 0, 0, 0), (k <= 3), 1'b0);
         s.rst = (k == 3);
         tick(s);
         e = expq.pop_front(); checks++;
         if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {e.v, e.rgb}) begin
            failures++;
            $display("FAIL mid_reset[%0d]: got v=%b rgb=%h%h%h expected v=%b rgb=%h",
                     k, pix_valid, VGA_R, VGA_G, VGA_B, e.v, e.rgb);
         end
         if (k == 3) begin
            checks++;
            if (pix_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
               failures++;
               $display("FAIL mid_reset_clear: got v=%b rgb=%h%h%h expected v=0 rgb=000000",
                        pix_valid, VGA_R, VGA_G, VGA_B);
            end
         end
         if (k == 4 + RL) begin
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
               failures++;
               $display("FAIL mid_reset_flash_cleared: got rgb=%h%h%h expected FFFFFF",
                        VGA_R, VGA_G, VGA_B);
            end
         end
      end
   endtask

   initial begin
      Reset = 1'b1; frame_start = 1'b0; shot = 1'b0; pixel_en = 1'b0;
      state = '0; is_cursor = 1'b0; layer_hit = '0; layer_color = '0;
      @(negedge Clk);
      test_reset();
      test_priority();
      test_flash();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the per-pixel colour selector.
- Takes N sprite layers, each as a hit flag plus palette colour, merges them by fixed priority with a transparency key, and overlays a cursor with a timed shot flash.
- Applies game-state screen modes and drives registered VGA RGB.
- Sits between the sprite ROM/palette fabric and the VGA controller; hides ROM read latency by delaying hit flags to match colour data.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; index 0 is highest priority.
- COLOR_W, 24, palette colour width (8 bits each R,G,B).
- ROM_LAT, 2, cycles from hit flag and address issue to palette colour valid (index ROM + palette ROM).
- TRANSPARENT, 24'hF442EE, colour key treated as "no pixel".
- BG_COLOR, 24'h0000F0, sky colour in game states.
- TITLE_COLOR, 24'h00F0F0, fill colour in title state.
- FLASH_FRAMES, 4, frames the cursor stays black after a shot; 0 disables the flash.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of each frame (vsync edge).
- pixel_en  in  1  current pixel is in the active display region.
- state  in  3  game state, aligned with the hit flags.
- layer_hit  in  NUM_LAYERS  per-layer "pixel inside sprite" flags, issued alongside ROM addresses.
- is_cursor  in  1  pixel is on the crosshair, aligned with the hit flags.
- shot  in  1  trigger level (button).
- layer_color  in  NUM_LAYERS*COLOR_W  palette outputs, layer i at bits [i*COLOR_W +: COLOR_W]; valid ROM_LAT cycles after the matching flags.
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour.
- pix_valid  out  1  delayed pixel_en, aligned with RGB.

Behaviour:
- Clock and reset: the block uses one clock and one reset. Reset is synchronous and active-high. The clock port is named Clk and the reset port Reset.
- Reset: VGA_R/G/B = 0, pix_valid = 0, all delay stages = 0, flash counter = 0, shot_q = 0. A reset asserted mid-frame clears all of this on the next edge. No stale pixels emerge afterward; the pipeline refills with zeros.

Pipeline:
- {layer_hit, is_cursor, state, pixel_en} pass through ROM_LAT register stages.
- Composition is combinational on the delayed flags and live layer_color.
- Result is registered into VGA_*.
- Total latency from flag input to RGB = ROM_LAT+1 cycles. Throughput is 1 pixel per clock with no stalls.

Composition, evaluated at the delayed stage:
- state 000 (TITLE): TITLE_COLOR.
- state 001, 010, 100 (GAME variants):
  - cursor first: black if flash_cnt != 0, else 24'hFFFFFF.
  - otherwise the lowest index i with hit[i]=1 and color[i] != TRANSPARENT.
  - otherwise BG_COLOR.
- state 011 (GAME OVER) and 101–111: black.
- Delayed pixel_en = 0: output black, regardless of state.
- All hit layers transparent: the pixel falls through to BG_COLOR. A transparent higher layer never masks a lower one.

Flash counter (width clog2(FLASH_FRAMES+1)):
- shot_q registers shot. A rising edge (shot & ~shot_q) loads FLASH_FRAMES.
- Otherwise, on frame_start with counter != 0, decrement by 1.
- Rising edge coincident with frame_start: the load wins.
- Holding shot high does not retrigger.
- A new rising edge while counting reloads to FLASH_FRAMES.
- The counter saturates at 0 and never wraps.
- The counter is not delayed. It changes the cursor colour from the next composed pixel.

Decomposition:
- compositor_pkg:
  - game_state_e enum: TITLE=000, GAME_A=001, GAME_B=010, GAME_OVER=011, GAME_C=100.
  - default TRANSPARENT, BG_COLOR, TITLE_COLOR constants.
  - helper function is_game_state().
- Sub-module pipe_delay (params WIDTH, DEPTH; DEPTH=0 is a wire; sync reset to 0). Instantiated once for the bundled flag vector.
- The priority select is a for-loop in the top module, not a separate module.

Test Plan:
- Reset with flags active for 3 cycles, release -> RGB=0 and pix_valid=0 during reset and until ROM_LAT+1 cycles after the first valid input.
- state=001, hit=4'b0011, color0=F442EE, color1=123456, pixel_en=1 -> RGB=12/34/56 exactly 3 cycles later.
- state=001, hit=4'b0000 -> 00/00/F0. state=000 with any hits -> 00/F0/F0. state=011 -> 00/00/00.
- Cursor plus shot rising edge, then 4 frame_start pulses:
  - cursor pixels are black through the 4th pulse, white after.
  - shot held high for 10 frames gives no retrigger.
  - shot edge coincident with frame_start gives counter=4.
- Back-to-back pixels alternating hit=4'b1000 (color3=00FF00) and 4'b0001 (color0=FF0000) -> output alternates each clock with a 3-cycle offset; no bubbles.
- Reset asserted mid-frame for one cycle -> next RGB is 0 and the flash counter is 0.
